// File: rtl/moo_ghash_pkg.sv
// Shared definitions for the GCM GHASH path: op codes, sequencer state encoding, counter width.
// Latency: n/a (package only).
// Backpressure: n/a.
package moo_ghash_pkg;

  // Block-counter width; holds ceil(2^32/16) message blocks.
  localparam int CNT_W = 29;

  // GHASH operation codes, shared with the GHASH unit.
  localparam logic [1:0] GHASH_WRD   = 2'b00;
  localparam logic [1:0] GHASH_ENC   = 2'b01;
  localparam logic [1:0] GHASH_NNC_F = 2'b10;
  localparam logic [1:0] GHASH_GCM_F = 2'b11;

  // One-hot sequencer state encoding.
  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_CLR  = 6'b000010;
  localparam logic [5:0] ST_DAT  = 6'b000100;
  localparam logic [5:0] ST_MSG  = 6'b001000;
  localparam logic [5:0] ST_LEN  = 6'b010000;
  localparam logic [5:0] ST_WAIT = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE = ST_IDLE,
    S_CLR  = ST_CLR,
    S_DAT  = ST_DAT,
    S_MSG  = ST_MSG,
    S_LEN  = ST_LEN,
    S_WAIT = ST_WAIT
  } state_t;

endpackage

// File: rtl/moo_blk_ceil.sv
// Converts a byte count into a 16-byte block count, rounding up: ceil(bytes/16).
// Latency: combinational.
// Backpressure: none.
// Ports: i_bytes - byte count (32 bits); o_blk - block count (CNT_W bits).
module moo_blk_ceil #(
  parameter int CNT_W = moo_ghash_pkg::CNT_W
) (
  input  logic [31:0]      i_bytes,
  output logic [CNT_W-1:0] o_blk
);

  // Whole blocks plus one more for any partial tail; no full-width carry chain needed.
  assign o_blk = CNT_W'(i_bytes[31:4]) + CNT_W'(|i_bytes[3:0]);

endmodule

// File: rtl/moo_ghash_seq.sv
// Sequences GHASH block issues for one GCM tag (AAD, ciphertext, length) or one J0 nonce hash.
// Latency: start@t -> ghash_clr@t+1 -> first ghash_en@t+2; done on first ghash_rdy after the length issue.
// Backpressure: stalls in place while ghash_rdy or the phase source valid is low; no timeout.
// Ports:
//   i_clk, i_rst_n (async active-low), i_clr_core (sync abort)
//   i_start, i_nnc_mode, i_size_add, i_size_msg, i_wr_size - command and sizes, sampled at start
//   i_wb_vld / o_wb_ack   - AAD or nonce block from the write buffer
//   i_xfb_vld / o_xfb_ack - ciphertext block from the cipher feedback path
//   i_ghash_rdy, o_ghash_en, o_ghash_op, o_ghash_clr - GHASH unit control
//   o_msg_done, o_busy, o_done - sequence status
module moo_ghash_seq
  import moo_ghash_pkg::*;
#(
  parameter int CNT_W = moo_ghash_pkg::CNT_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr_core,
  input  logic        i_start,
  input  logic        i_nnc_mode,
  input  logic [15:0] i_size_add,
  input  logic [31:0] i_size_msg,
  input  logic [15:0] i_wr_size,
  input  logic        i_wb_vld,
  output logic        o_wb_ack,
  input  logic        i_xfb_vld,
  output logic        o_xfb_ack,
  input  logic        i_ghash_rdy,
  output logic        o_ghash_en,
  output logic [1:0]  o_ghash_op,
  output logic        o_ghash_clr,
  output logic        o_msg_done,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_d_cnt;
  logic [CNT_W-1:0] r_m_cnt;
  logic             r_nnc;
  logic             r_en_q;

  logic [31:0]      w_nnc_bytes;
  logic [31:0]      w_dat_bytes;
  logic [CNT_W-1:0] w_d_blk;
  logic [CNT_W-1:0] w_m_raw;
  logic [CNT_W-1:0] w_m_blk;
  logic             w_start;
  logic             w_can_issue;

  // wr_size carries the IV length plus 4; anything at or below 4 means no IV blocks.
  assign w_nnc_bytes = (i_wr_size > 16'd4) ? {16'h0000, i_wr_size - 16'd4} : 32'h0000_0000;
  assign w_dat_bytes = i_nnc_mode ? w_nnc_bytes : {16'h0000, i_size_add};

  moo_blk_ceil #(.CNT_W(CNT_W)) u_dat_ceil (
    .i_bytes (w_dat_bytes),
    .o_blk   (w_d_blk)
  );

  moo_blk_ceil #(.CNT_W(CNT_W)) u_msg_ceil (
    .i_bytes (i_size_msg),
    .o_blk   (w_m_raw)
  );

  assign w_m_blk = i_nnc_mode ? '0 : w_m_raw;

  // start is only honoured from IDLE, and a coincident clr_core drops it.
  assign w_start = i_start & ~i_clr_core & (r_state == S_IDLE);

  // Never issue on two consecutive cycles: ghash_rdy may lag the issue by one cycle.
  assign w_can_issue = i_ghash_rdy & ~r_en_q;

  assign o_busy = (r_state != S_IDLE);

  always_comb begin
    w_next      = r_state;
    o_ghash_en  = 1'b0;
    o_ghash_op  = GHASH_WRD;
    o_ghash_clr = 1'b0;
    o_wb_ack    = 1'b0;
    o_xfb_ack   = 1'b0;
    o_msg_done  = 1'b0;
    o_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_CLR;
      end
      S_CLR: begin
        o_ghash_clr = 1'b1;
        if (r_d_cnt != '0)      w_next = S_DAT;
        else if (r_m_cnt != '0) w_next = S_MSG;
        else                    w_next = S_LEN;
      end
      S_DAT: begin
        o_ghash_op = GHASH_WRD;
        if (w_can_issue && i_wb_vld) begin
          o_ghash_en = 1'b1;
          o_wb_ack   = 1'b1;
          if (r_d_cnt <= L_CNT_ONE) w_next = (r_m_cnt != '0) ? S_MSG : S_LEN;
        end
      end
      S_MSG: begin
        o_ghash_op = GHASH_ENC;
        o_msg_done = (r_m_cnt == L_CNT_ONE);
        if (w_can_issue && i_xfb_vld) begin
          o_ghash_en = 1'b1;
          o_xfb_ack  = 1'b1;
          if (r_m_cnt <= L_CNT_ONE) w_next = S_LEN;
        end
      end
      S_LEN: begin
        // The nonce flow carries no message, so msg_done stays low there.
        o_ghash_op = r_nnc ? GHASH_NNC_F : GHASH_GCM_F;
        o_msg_done = ~r_nnc;
        if (w_can_issue) begin
          o_ghash_en = 1'b1;
          w_next     = S_WAIT;
        end
      end
      S_WAIT: begin
        o_ghash_op = r_nnc ? GHASH_NNC_F : GHASH_GCM_F;
        o_msg_done = ~r_nnc;
        if (i_ghash_rdy) begin
          o_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase

    // Core clear overrides everything, including a done that would fire this cycle.
    if (i_clr_core) begin
      w_next      = S_IDLE;
      o_ghash_en  = 1'b0;
      o_ghash_clr = 1'b0;
      o_wb_ack    = 1'b0;
      o_xfb_ack   = 1'b0;
      o_done      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_d_cnt <= '0;
      r_m_cnt <= '0;
      r_nnc   <= 1'b0;
      r_en_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_en_q  <= o_ghash_en;
      if (i_clr_core) begin
        r_d_cnt <= '0;
        r_m_cnt <= '0;
      end else if (w_start) begin
        // Counts are captured with the command; CLR then reads them to pick the first phase.
        r_d_cnt <= w_d_blk;
        r_m_cnt <= w_m_blk;
        r_nnc   <= i_nnc_mode;
      end else if (o_ghash_en) begin
        if (r_state == S_DAT && r_d_cnt != '0) r_d_cnt <= r_d_cnt - L_CNT_ONE;
        if (r_state == S_MSG && r_m_cnt != '0) r_m_cnt <= r_m_cnt - L_CNT_ONE;
      end
    end
  end

endmodule

// File: doc/moo_ghash_seq.md
# moo_ghash_seq

Sequencer for the GHASH engine in the GCM path of the crypto core.
- Takes one start command plus the AAD and message byte counts, then issues every GHASH block in order: AAD blocks, ciphertext blocks, final length block.
- A nonce mode hashes a non-96-bit IV instead and finishes with the nonce length block.
- Sits between the core FSM (command, sizes), the write buffer (AAD/nonce blocks), the cipher feedback path (ciphertext blocks) and the GHASH unit (ghash_en/ghash_op/ghash_clr/ghash_rdy).

## Interface
Parameters:
- CNT_W, 29: block-counter width; must hold ceil(2^32/16).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- clr_core  in  1  synchronous core clear; aborts any sequence
- start  in  1  one-cycle command; ignored while busy=1
- nnc_mode  in  1  sampled at start: 0 = GCM tag flow, 1 = nonce (J0) flow
- size_add  in  16  AAD bytes, sampled at start
- size_msg  in  32  message bytes, sampled at start
- wr_size  in  16  nonce bytes + 4, sampled at start
- wb_vld  in  1  write buffer presents an AAD/nonce block
- wb_ack  out  1  block consumed (same cycle as ghash_en)
- xfb_vld  in  1  cipher feedback presents a ciphertext block
- xfb_ack  out  1  block consumed (same cycle as ghash_en)
- ghash_rdy  in  1  GHASH unit idle
- ghash_en  out  1  one-cycle block issue
- ghash_op  out  2  00 WRD, 01 ENC, 10 NNC_F, 11 GCM_F
- ghash_clr  out  1  one-cycle GHASH accumulator clear
- msg_done  out  1  current ENC issue is the last message block
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse: final block hashed, ghash output valid

## Operation
- Reset values: wb_ack, xfb_ack, ghash_en, ghash_clr, msg_done, busy, done = 0; ghash_op = 00; state = IDLE; counters = 0.
- Block counts at start, computed at full width with no truncation:
  - d_blk = ceil(size_add/16) in GCM mode, ceil((wr_size-4)/16) in nonce mode.
  - m_blk = ceil(size_msg/16), forced to 0 in nonce mode.
- States:
  - IDLE: start -> CLR.
  - CLR: ghash_clr=1 for one cycle, then -> DAT, or MSG if d_blk=0, or LEN if d_blk=m_blk=0.
  - DAT: issue WRD blocks from wb. After d_blk issues -> MSG, or LEN if m_blk=0.
  - MSG: issue ENC blocks from xfb. After m_blk issues -> LEN.
  - LEN: issue GCM_F (nnc_mode=0) or NNC_F (nnc_mode=1); needs no source valid -> WAIT.
  - WAIT: first cycle with ghash_rdy=1: done=1, -> IDLE.
- Issue rule: ghash_en=1 only if ghash_rdy=1, the phase source is valid, and ghash_en was 0 in the previous cycle. The matching ack rises in the same cycle.
- ghash_op is driven by state: DAT 00, MSG 01, LEN 10/11; held at 00 in IDLE.
- msg_done=1 in MSG while the remaining count is 1, and in LEN/WAIT.
- busy=1 in every state except IDLE.
- clr_core has priority over everything: next state IDLE, counters 0, no done pulse.
- start while busy is ignored. start together with clr_core is dropped.

## Timing
- start at cycle t -> ghash_clr at t+1 -> earliest ghash_en at t+2.
- GHASH occupies 16 cycles after each ghash_en; ghash_rdy is low t+1..t+16. Minimum issue period is 17 cycles.
- Source valids may drop between issues. The sequencer stalls in its state with no timeout.
- done rises exactly the first cycle ghash_rdy is high after the LEN issue. busy falls the next cycle.
- Counters: down-counters loaded at CLR, decremented per issue. 0 is terminal; no wrap.

## Structure
- Shared package moo_ghash_pkg holds:
  - op codes GHASH_WRD/ENC/NNC_F/GCM_F, also used by the GHASH unit;
  - the state encoding (one-hot localparams);
  - CNT_W.
- One sub-module, moo_blk_ceil: combinational ceil(bytes/16) at CNT_W, instantiated twice.

## Test plan
- GCM, size_add=20, size_msg=32, all valids high, start at cycle 0 -> ghash_clr@1; ghash_en@2,19,36,53,70 with ops 00,00,01,01,11; msg_done high at the 53 issue; done@87.
- size_add=0, size_msg=0 -> CLR then LEN directly: one GCM_F issue @2, done@19.
- nonce mode, wr_size=36 (32-byte IV) -> two WRD issues, then NNC_F; no ENC; msg_done never high.
- size_msg=17 with xfb_vld low for 40 cycles after the first ENC -> second ENC waits for xfb_vld, with msg_done=1 on it; no ack without ghash_en.
- clr_core at cycle 30 of a 5-block sequence -> busy=0 next cycle, no done, no further ghash_en; a new start then runs normally.
- start asserted while busy -> ignored; block counts and issue sequence unchanged.
